// File: rtl/mat_mul_stream_ctrl_pkg.sv
// Shared types and index constants for the 2x2 matrix-multiply stream controller.
package mat_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam int NUM_OPERANDS = 8;
    localparam int NUM_RESULTS  = 4;

    // Operand order on the input stream
    localparam int IDX_A11 = 0;
    localparam int IDX_A12 = 1;
    localparam int IDX_A21 = 2;
    localparam int IDX_A22 = 3;
    localparam int IDX_B11 = 4;
    localparam int IDX_B12 = 5;
    localparam int IDX_B21 = 6;
    localparam int IDX_B22 = 7;

    // Result order on the output stream
    localparam int IDX_C11 = 0;
    localparam int IDX_C12 = 1;
    localparam int IDX_C21 = 2;
    localparam int IDX_C22 = 3;

endpackage

// File: rtl/mat_mul_stream_ctrl_if.sv
// Operand/result streams plus the multiplier-side handshake of the controller.
interface mat_mul_stream_ctrl_if #(parameter int N = 10);

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_data;

    logic [N-1:0]   mul_A11, mul_A12, mul_A21, mul_A22;
    logic [N-1:0]   mul_B11, mul_B12, mul_B21, mul_B22;
    logic           mul_start;
    logic           mul_done;
    logic [2*N-1:0] mul_C11, mul_C12, mul_C21, mul_C22;

    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_data;
    logic           out_last;
    logic           frame_done;
    logic           err_timeout;

    // master = the controller, slave = upstream/multiplier/downstream environment
    modport master (
        input  in_valid, in_data, mul_done,
        input  mul_C11, mul_C12, mul_C21, mul_C22, out_ready,
        output in_ready, mul_start,
        output mul_A11, mul_A12, mul_A21, mul_A22,
        output mul_B11, mul_B12, mul_B21, mul_B22,
        output out_valid, out_data, out_last, frame_done, err_timeout
    );

    modport slave (
        output in_valid, in_data, mul_done,
        output mul_C11, mul_C12, mul_C21, mul_C22, out_ready,
        input  in_ready, mul_start,
        input  mul_A11, mul_A12, mul_A21, mul_A22,
        input  mul_B11, mul_B12, mul_B21, mul_B22,
        input  out_valid, out_data, out_last, frame_done, err_timeout
    );

endinterface

// File: rtl/mat_mul_stream_ctrl.sv
// Serial-in / serial-out initiator for the 2x2 multiplier; owns the start/done handshake.
//   state | meaning
//   LOAD  | accept operand words 0..7 from the input stream
//   START | one-cycle mul_start pulse, timeout counter cleared
//   WAIT  | wait for mul_done, abort the frame after DONE_TIMEOUT-1 idle cycles
//   SEND  | emit C11..C22 on the output stream
module mat_mul_stream_ctrl
    import mat_pkg::*;
#(
    parameter int N            = 10,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mat_mul_stream_ctrl_if.master bus
);

    localparam int TW = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DONE_TIMEOUT - 2);
    localparam logic [2:0]    W_LAST = 3'(NUM_OPERANDS - 1);
    localparam logic [1:0]    R_LAST = 2'(IDX_C22);

    state_t         state, state_nxt;
    logic [2:0]     wcnt, wcnt_nxt;
    logic [1:0]     ridx, ridx_nxt;
    logic [TW-1:0]  tcnt, tcnt_nxt;
    logic           load_en, cap_en;
    logic           err_nxt, fdone_nxt;
    logic           err_q, fdone_q;

    logic [N-1:0]   opnd [NUM_OPERANDS];
    logic [2*N-1:0] res  [NUM_RESULTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            wcnt    <= '0;
            ridx    <= '0;
            tcnt    <= '0;
            err_q   <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            ridx    <= ridx_nxt;
            tcnt    <= tcnt_nxt;
            err_q   <= err_nxt;
            fdone_q <= fdone_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        ridx_nxt  = ridx;
        tcnt_nxt  = tcnt;
        load_en   = 1'b0;
        cap_en    = 1'b0;
        err_nxt   = 1'b0;
        fdone_nxt = 1'b0;
        case (state)
            LOAD: begin
                if (bus.in_valid) begin
                    load_en = 1'b1;
                    if (wcnt == W_LAST) begin
                        wcnt_nxt  = '0;
                        state_nxt = START;
                    end else begin
                        wcnt_nxt = wcnt + 3'd1;
                    end
                end
            end
            START: begin
                tcnt_nxt  = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mul_done) begin
                    cap_en    = 1'b1;
                    ridx_nxt  = '0;
                    state_nxt = SEND;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                    // counter is about to reach DONE_TIMEOUT-1: give up on this frame
                    if (tcnt == T_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (ridx == R_LAST) begin
                        fdone_nxt = 1'b1;
                        ridx_nxt  = '0;
                        state_nxt = LOAD;
                    end else begin
                        ridx_nxt = ridx + 2'd1;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OPERANDS; i++) opnd[i] <= '0;
            for (int i = 0; i < NUM_RESULTS; i++)  res[i]  <= '0;
        end else begin
            if (load_en) opnd[wcnt] <= bus.in_data;
            if (cap_en) begin
                res[IDX_C11] <= bus.mul_C11;
                res[IDX_C12] <= bus.mul_C12;
                res[IDX_C21] <= bus.mul_C21;
                res[IDX_C22] <= bus.mul_C22;
            end
        end
    end

    assign bus.in_ready    = (state == LOAD);
    assign bus.mul_start   = (state == START);
    assign bus.out_valid   = (state == SEND);
    assign bus.out_last    = (state == SEND) && (ridx == R_LAST);
    assign bus.out_data    = res[ridx];
    assign bus.frame_done  = fdone_q;
    assign bus.err_timeout = err_q;

    // Operands only change in LOAD, so the multiplier sees them stable through capture
    assign bus.mul_A11 = opnd[IDX_A11];
    assign bus.mul_A12 = opnd[IDX_A12];
    assign bus.mul_A21 = opnd[IDX_A21];
    assign bus.mul_A22 = opnd[IDX_A22];
    assign bus.mul_B11 = opnd[IDX_B11];
    assign bus.mul_B12 = opnd[IDX_B12];
    assign bus.mul_B21 = opnd[IDX_B21];
    assign bus.mul_B22 = opnd[IDX_B22];

endmodule

// File: tb/tb_mat_mul_stream_ctrl.sv
// Directed and randomized frames against a matrix-arithmetic reference for mat_mul_stream_ctrl.
module tb_mat_mul_stream_ctrl;

    localparam int N  = 10;
    localparam int W  = 2 * N;
    localparam int TO = 16;

    typedef int frame_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mul_en = 1'b1;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int starts = 0;
    int errs   = 0;
    int fdones = 0;

    mat_mul_stream_ctrl_if #(.N(N)) bus ();

    mat_mul_stream_ctrl #(.N(N), .DONE_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.mul_start)   starts <= starts + 1;
            if (bus.err_timeout) errs   <= errs + 1;
            if (bus.frame_done)  fdones <= fdones + 1;
        end
    end

    // Stand-in for the multiplier datapath: answers one cycle after start
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mul_done <= 1'b0;
            bus.mul_C11  <= '0;
            bus.mul_C12  <= '0;
            bus.mul_C21  <= '0;
            bus.mul_C22  <= '0;
        end else begin
            bus.mul_done <= bus.mul_start & mul_en;
            bus.mul_C11  <= W'(bus.mul_A11) * W'(bus.mul_B11) + W'(bus.mul_A12) * W'(bus.mul_B21);
            bus.mul_C12  <= W'(bus.mul_A11) * W'(bus.mul_B12) + W'(bus.mul_A12) * W'(bus.mul_B22);
            bus.mul_C21  <= W'(bus.mul_A21) * W'(bus.mul_B11) + W'(bus.mul_A22) * W'(bus.mul_B21);
            bus.mul_C22  <= W'(bus.mul_A21) * W'(bus.mul_B12) + W'(bus.mul_A22) * W'(bus.mul_B22);
        end
    end

    // Row i of A times column j of B, reduced mod 2^W
    function automatic logic [W-1:0] ref_c(frame_t ops, int r);
        int    i, j;
        longint s;
        i = r / 2;
        j = r % 2;
        s = 0;
        for (int k = 0; k < 2; k++)
            s += longint'(ops[2*i + k]) * longint'(ops[4 + 2*k + j]);
        return W'(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put_word(input logic [N-1:0] d, output int acc);
        acc = -1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 100; t++) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) chk("in_accept_tmo", 64'(bus.in_ready), 64'(1));
    endtask

    task automatic load_frame(input frame_t ops, input bit gaps, output int k_first, output int k_last);
        int acc;
        k_first = 0;
        for (int i = 0; i < 8; i++) begin
            put_word(N'(ops[i]), acc);
            if (i == 0) k_first = acc;
            if (gaps && i < 7) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        k_last = acc;
        bus.in_valid = 1'b0;
    endtask

    // Called at the negedge of the cycle right after the last operand accept
    task automatic check_start(input frame_t ops);
        logic [N-1:0] mv [8];
        mv[0] = bus.mul_A11; mv[1] = bus.mul_A12; mv[2] = bus.mul_A21; mv[3] = bus.mul_A22;
        mv[4] = bus.mul_B11; mv[5] = bus.mul_B12; mv[6] = bus.mul_B21; mv[7] = bus.mul_B22;
        chk("mul_start_hi", 64'(bus.mul_start), 64'(1));
        chk("in_ready_start", 64'(bus.in_ready), 64'(0));
        for (int i = 0; i < 8; i++) chk("mul_operand", 64'(mv[i]), 64'(ops[i]));
        @(negedge clk);
        chk("mul_start_lo", 64'(bus.mul_start), 64'(0));
        chk("in_ready_wait", 64'(bus.in_ready), 64'(0));
        chk("out_valid_wait", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        chk("out_valid_latency", 64'(bus.out_valid), 64'(1));
    endtask

    // stall < 0 picks a random 0..3 stall per word
    task automatic recv_frame(input frame_t ops, input int stall, input int nwords);
        logic [W-1:0] exp;
        int nst;
        for (int r = 0; r < nwords; r++) begin
            exp = ref_c(ops, r);
            nst = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int t = 0; t < 40 && bus.out_valid !== 1'b1; t++) @(negedge clk);
            chk("out_valid", 64'(bus.out_valid), 64'(1));
            if (nst > 0) bus.out_ready = 1'b0;
            for (int s = 0; s < nst; s++) begin
                chk("stall_data", 64'(bus.out_data), 64'(exp));
                @(negedge clk);
            end
            chk("out_data", 64'(bus.out_data), 64'(exp));
            chk("out_last", 64'(bus.out_last), 64'(r == 3));
            chk("in_ready_send", 64'(bus.in_ready), 64'(0));
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        if (nwords == 4) begin
            chk("frame_done", 64'(bus.frame_done), 64'(1));
            chk("out_valid_end", 64'(bus.out_valid), 64'(0));
            chk("in_ready_end", 64'(bus.in_ready), 64'(1));
        end
    endtask

    task automatic rand_frame(output frame_t f);
        for (int i = 0; i < 8; i++) f[i] = int'($urandom_range(0, (1 << N) - 1));
    endtask

    initial begin
        frame_t f1, fmax, fid, fa, fb;
        int k0, k1, k2, s0, d0;

        f1   = '{1, 2, 3, 4, 5, 6, 7, 8};
        fid  = '{1, 0, 0, 1, 9, 8, 7, 6};
        for (int i = 0; i < 8; i++) fmax[i] = (1 << N) - 1;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_mul_start", 64'(bus.mul_start), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_err", 64'(bus.err_timeout), 64'(0));
        chk("rst_fdone", 64'(bus.frame_done), 64'(0));
        chk("rst_mul_a11", 64'(bus.mul_A11), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

        // Basic frame, streams held open
        s0 = starts; d0 = fdones;
        bus.out_ready = 1'b1;
        load_frame(f1, 1'b0, k0, k1);
        check_start(f1);
        recv_frame(f1, 0, 4);
        @(negedge clk);
        chk("basic_fdone_pulse", 64'(bus.frame_done), 64'(0));
        chk("basic_starts", 64'(starts - s0), 64'(1));
        chk("basic_fdones", 64'(fdones - d0), 64'(1));

        // Input gaps and 3-cycle output back-pressure
        s0 = starts;
        load_frame(f1, 1'b1, k0, k1);
        check_start(f1);
        recv_frame(f1, 3, 4);
        @(negedge clk);
        chk("gap_starts", 64'(starts - s0), 64'(1));

        // All-ones operands wrap at 2^W
        load_frame(fmax, 1'b0, k0, k1);
        check_start(fmax);
        recv_frame(fmax, 1, 4);
        @(negedge clk);

        // Multiplier never answers
        mul_en = 1'b0;
        d0 = errs;
        rand_frame(fa);
        load_frame(fa, 1'b0, k0, k1);
        chk("to_mul_start", 64'(bus.mul_start), 64'(1));
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            chk("to_err_early", 64'(bus.err_timeout), 64'(0));
            chk("to_no_valid", 64'(bus.out_valid), 64'(0));
        end
        @(negedge clk);
        chk("to_err_pulse", 64'(bus.err_timeout), 64'(1));
        chk("to_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        chk("to_err_clear", 64'(bus.err_timeout), 64'(0));
        chk("to_in_ready_next", 64'(bus.in_ready), 64'(1));
        chk("to_err_count", 64'(errs - d0), 64'(1));
        mul_en = 1'b1;
        rand_frame(fa);
        load_frame(fa, 1'b0, k0, k1);
        check_start(fa);
        recv_frame(fa, 0, 4);
        @(negedge clk);

        // Reset after the C12 handshake
        rand_frame(fa);
        fa[0] = int'($urandom_range(1, (1 << N) - 1));
        fa[7] = int'($urandom_range(1, (1 << N) - 1));
        load_frame(fa, 1'b0, k0, k1);
        check_start(fa);
        recv_frame(fa, 0, 2);
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mrst_out_data", 64'(bus.out_data), 64'(0));
        chk("mrst_out_last", 64'(bus.out_last), 64'(0));
        chk("mrst_mul_a11", 64'(bus.mul_A11), 64'(0));
        chk("mrst_mul_b22", 64'(bus.mul_B22), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("mrst_out_valid_after", 64'(bus.out_valid), 64'(0));
        load_frame(fid, 1'b0, k0, k1);
        check_start(fid);
        recv_frame(fid, 0, 4);
        @(negedge clk);

        // Back-to-back frames with in_valid never dropping
        rand_frame(fa);
        rand_frame(fb);
        load_frame(fa, 1'b0, k0, k1);
        bus.in_valid = 1'b1;
        bus.in_data  = N'(fb[0]);
        check_start(fa);
        recv_frame(fa, 0, 4);
        load_frame(fb, 1'b0, k2, k0);
        chk("b2b_next_accept", 64'(k2 - k1), 64'(7));
        check_start(fb);
        recv_frame(fb, 0, 4);
        @(negedge clk);

        // Random frames, random gaps and stalls
        for (int n = 0; n < 6; n++) begin
            rand_frame(fa);
            load_frame(fa, bit'($urandom_range(0, 1)), k0, k1);
            check_start(fa);
            recv_frame(fa, -1, 4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mat_mul_stream_ctrl.md
Name: mat_mul_stream_ctrl

Overview:
Stream-side initiator for the 2x2 matrix multiply datapath. It accepts the 8 operand words serially over a valid/ready input stream and presents them in parallel to the multiplier. It then pulses start, waits for done, captures the 4 results and emits them serially over a valid/ready output stream. It owns the start/done handshake so that upstream logic never drives the multiplier directly.

Parameters:
N, 10, operand width; result width is 2*N
DONE_TIMEOUT, 16, max cycles spent in WAIT for mul_done before the frame is aborted (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand word valid
in_ready  out  1  controller can accept an operand word
in_data  in  N  operand word, order A11,A12,A21,A22,B11,B12,B21,B22
mul_A11..mul_A22  out  N each  operand A to multiplier
mul_B11..mul_B22  out  N each  operand B to multiplier
mul_start  out  1  one-cycle start pulse to multiplier
mul_done  in  1  multiplier completion
mul_C11..mul_C22  in  2*N each  multiplier results
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts result word
out_data  out  2*N  result word, order C11,C12,C21,C22
out_last  out  1  high with the C22 word
frame_done  out  1  one-cycle pulse when C22 is accepted
err_timeout  out  1  one-cycle pulse on WAIT timeout

Behaviour:
- Reset (async, rst=1):
  - state=LOAD, word and result counters=0, timeout counter=0.
  - All mul_A/mul_B regs, result regs and out_data = 0.
  - mul_start, out_valid, out_last, frame_done, err_timeout = 0.
- in_ready = (state==LOAD). It is therefore 1 in the first cycle after reset deasserts. out_valid = (state==SEND).
- LOAD:
  - Each cycle with in_valid&in_ready, store in_data into the operand reg selected by word counter 0..7, then increment.
  - Gaps in in_valid are allowed and hold the count.
  - On acceptance of word 7: counter->0, next state START.
- START: mul_start=1 for exactly this cycle; next state WAIT; timeout counter cleared.
- WAIT:
  - mul_start=0.
  - If mul_done=1: capture mul_C11..C22 into result regs, next SEND with index 0.
  - Else increment the timeout counter. If it reaches DONE_TIMEOUT-1 without done, pulse err_timeout for one cycle, discard the frame and return to LOAD. Operand regs are not cleared.
  - A mul_done seen in any other state is ignored.
- SEND:
  - out_data = result[index], out_last = (index==3).
  - out_data is stable while out_valid&!out_ready (AXI-style; valid never drops without a handshake).
  - On out_ready, advance index. On acceptance of index 3: frame_done pulses the next cycle, state returns to LOAD.
- Operand outputs are stable from START through capture, because in_ready=0 outside LOAD.
- Latency: last operand accepted at edge k -> mul_start high cycle k+1 -> mul_done cycle k+2 -> out_valid cycle k+3. With out_ready held high, the 4 words take 4 cycles, and the next operand is accepted at cycle k+7 earliest.
- Width: results pass through unmodified at 2*N bits. Overflow is mod 2^(2N) in the multiplier; no saturation here.
- Reset mid-frame: all in-flight data is discarded. After deassertion, in_ready=1 and out_valid=0.
- No overlap: the next frame does not load while SEND is active.

Decomposition:
- Package mat_pkg:
  - state enum {LOAD, START, WAIT, SEND}.
  - NUM_OPERANDS=8, NUM_RESULTS=4.
  - Operand index constants IDX_A11..IDX_B22 and result index constants IDX_C11..IDX_C22.
- Single module; no sub-module needed. Bench instantiates it with the existing datapath.

Test Plan:
- Basic frame, N=10: A=[1,2;3,4], B=[5,6;7,8], in_valid and out_ready held high -> one mul_start pulse; outputs 19,22,43,50; out_last on 50; frame_done one cycle later; first out_valid 3 cycles after the last operand accept.
- Input gaps plus output back-pressure: in_valid toggling 1/0; out_ready low 3 cycles on each word -> same 19,22,43,50; out_data stable while stalled; exactly one mul_start.
- Max operands: all 8 words = 1023 -> every result = 2093058 mod 2^20 = 1044482.
- Timeout: mul_done tied 0 -> err_timeout pulses once, 16 cycles after START; no out_valid; in_ready=1 next cycle. A following good frame then produces correct results.
- Reset mid-SEND: assert rst after the C12 handshake -> out_valid and all outputs 0 immediately; in_ready=1 after deassertion. A fresh identity-times-B frame (A=[1,0;0,1], B=[9,8;7,6]) -> 9,8,7,6.
- Back-to-back frames with in_valid always high -> in_ready=0 during START, WAIT and SEND; second frame results correct; no operand corruption.
